object_spawn_dispatcher: RTL and testbench

- ROM-side issuer for the object-spawn handshake.
- Walks a pattern ROM of object entries, waits each entry's scheduled delay in centi-second ticks, then presents the object fields on the shared object bus.
- Drives `sync_object_position` low and holds the fields until the multi-object runtime acknowledges with `update_object_position`, then advances.
- Sits between the pattern ROM and the object trigger runtime in the calculation clock domain.

---
 rtl/object_spawn_dispatcher_if.sv | 40 ++++
 rtl/object_spawn_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_object_spawn_dispatcher.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_spawn_dispatcher_if.sv
// Object bus between the spawn dispatcher (master) and the multi-object
// runtime (slave): latched object fields plus the sync/update handshake.
interface object_spawn_dispatcher_if;
    logic [2:0] object_movement_direction;
    logic [9:0] object_pos_x;
    logic [9:0] object_pos_y;
    logic [9:0] object_w;
    logic [9:0] object_h;
    logic [4:0] object_speed;
    logic [7:0] object_destroy_time;
    logic [1:0] object_destroy_trigger;
    logic       sync_object_position;
    logic       update_object_position;

    modport master (
        output object_movement_direction,
        output object_pos_x,
        output object_pos_y,
        output object_w,
        output object_h,
        output object_speed,
        output object_destroy_time,
        output object_destroy_trigger,
        output sync_object_position,
        input  update_object_position
    );

    modport slave (
        input  object_movement_direction,
        input  object_pos_x,
        input  object_pos_y,
        input  object_w,
        input  object_h,
        input  object_speed,
        input  object_destroy_time,
        input  object_destroy_trigger,
        input  sync_object_position,
        output update_object_position
    );
endinterface

// File: rtl/object_spawn_dispatcher.sv
// Object spawn dispatcher: walks the pattern ROM, waits each entry's
// centi-second delay, then presents the entry on the object bus with
// sync_object_position low until the runtime acknowledges (or the ack
// times out, in which case the entry is counted as dropped).
module object_spawn_dispatcher #(
    parameter int ADDR_WIDTH     = 8,
    parameter int PATTERN_LENGTH = 16,
    parameter int ACK_TIMEOUT    = 1023
) (
    input  logic                         clk_calculation,
    input  logic                         reset,
    input  logic                         tick_centi_second,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [66:0]                  rom_data,
    object_spawn_dispatcher_if.master    obj_bus,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   dropped_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT_TIME,
        ISSUE,
        RELEASE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(PATTERN_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE      = ADDR_WIDTH'(1);
    localparam logic [15:0]           TIMEOUT_LIMIT = 16'(ACK_TIMEOUT);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_next;
    logic [57:0]             fields;
    logic [57:0]             fields_next;
    logic [7:0]              wait_cnt;
    logic [7:0]              wait_cnt_next;
    logic [15:0]             timeout_cnt;
    logic [15:0]             timeout_cnt_next;
    logic [15:0]             timeout_inc;
    logic                    sync;
    logic                    sync_next;
    logic [7:0]              dropped_next;

    // Drop counter holds at 255 rather than wrapping back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    assign timeout_inc = timeout_cnt + 16'd1;

    // Next-state and next-register values; every target defaults to hold.
    always_comb begin
        state_next       = state;
        rom_addr_next    = rom_addr;
        fields_next      = fields;
        wait_cnt_next    = wait_cnt;
        timeout_cnt_next = timeout_cnt;
        sync_next        = sync;
        dropped_next     = dropped_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    rom_addr_next = '0;
                    dropped_next  = '0;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                // ROM address was presented last edge; data is valid next cycle.
                state_next = LATCH;
            end
            LATCH: begin
                fields_next      = rom_data[57:0];
                wait_cnt_next    = rom_data[65:58];
                timeout_cnt_next = '0;
                if (rom_data[66]) begin
                    state_next = DONE;
                end else if (rom_data[65:58] == 8'd0) begin
                    sync_next  = 1'b0;
                    state_next = ISSUE;
                end else begin
                    state_next = WAIT_TIME;
                end
            end
            WAIT_TIME: begin
                if (tick_centi_second) begin
                    wait_cnt_next = wait_cnt - 8'd1;
                    if (wait_cnt == 8'd1) begin
                        sync_next  = 1'b0;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timeout_cnt_next = timeout_inc;
                // An ack on the timeout cycle still counts as delivered.
                if (obj_bus.update_object_position) begin
                    sync_next  = 1'b1;
                    state_next = RELEASE;
                end else if (timeout_inc == TIMEOUT_LIMIT) begin
                    sync_next    = 1'b1;
                    dropped_next = sat_inc8(dropped_count);
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the runtime to drop its ack before the next entry.
                if (!obj_bus.update_object_position) begin
                    if (rom_addr == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        rom_addr_next = rom_addr + ADDR_ONE;
                        state_next    = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_calculation) begin
        if (reset) begin
            state         <= IDLE;
            rom_addr      <= '0;
            fields        <= '0;
            wait_cnt      <= '0;
            timeout_cnt   <= '0;
            sync          <= 1'b1;
            dropped_count <= '0;
        end else begin
            state         <= state_next;
            rom_addr      <= rom_addr_next;
            fields        <= fields_next;
            wait_cnt      <= wait_cnt_next;
            timeout_cnt   <= timeout_cnt_next;
            sync          <= sync_next;
            dropped_count <= dropped_next;
        end
    end

    assign obj_bus.object_movement_direction = fields[57:55];
    assign obj_bus.object_pos_x              = fields[54:45];
    assign obj_bus.object_pos_y              = fields[44:35];
    assign obj_bus.object_w                  = fields[34:25];
    assign obj_bus.object_h                  = fields[24:15];
    assign obj_bus.object_speed              = fields[14:10];
    assign obj_bus.object_destroy_time       = fields[9:2];
    assign obj_bus.object_destroy_trigger    = fields[1:0];
    assign obj_bus.sync_object_position      = sync;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_object_spawn_dispatcher.sv
// Scoreboard bench for object_spawn_dispatcher: directed ROM patterns,
// a behavioural runtime that acks on the object bus, and a monitor that
// pops expected entries whenever sync_object_position falls.
module tb_object_spawn_dispatcher;

    localparam int ADDR_WIDTH     = 8;
    localparam int PATTERN_LENGTH = 256;
    localparam int ACK_TIMEOUT    = 8;

    typedef struct {
        logic [57:0] f;
        int          fall_at;
        int          low_len;
    } exp_t;

    logic                  clk_calculation;
    logic                  reset;
    logic                  tick_centi_second;
    logic                  start;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [66:0]           rom_data;
    logic                  busy;
    logic                  done;
    logic [7:0]            dropped_count;

    object_spawn_dispatcher_if obj_bus ();

    object_spawn_dispatcher #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .PATTERN_LENGTH (PATTERN_LENGTH),
        .ACK_TIMEOUT    (ACK_TIMEOUT)
    ) dut (
        .clk_calculation   (clk_calculation),
        .reset             (reset),
        .tick_centi_second (tick_centi_second),
        .start             (start),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .obj_bus           (obj_bus),
        .busy              (busy),
        .done              (done),
        .dropped_count     (dropped_count)
    );

    logic [66:0] rom [256];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          abort = 0;
    bit          never_ack = 0;
    int          ack_delay = 2;
    int          ack_hold = 0;

    initial clk_calculation = 1'b0;
    always #5 clk_calculation = ~clk_calculation;

    always @(posedge clk_calculation) cyc <= cyc + 1;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk_calculation) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [66:0] mk(input logic e, input logic [7:0] wt, input logic [2:0] dir,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] w, input logic [9:0] h,
                                       input logic [4:0] spd, input logic [7:0] dt,
                                       input logic [1:0] dtr);
        return {e, wt, dir, x, y, w, h, spd, dt, dtr};
    endfunction

    function automatic logic [57:0] bus_fields();
        return {obj_bus.object_movement_direction, obj_bus.object_pos_x, obj_bus.object_pos_y,
                obj_bus.object_w, obj_bus.object_h, obj_bus.object_speed,
                obj_bus.object_destroy_time, obj_bus.object_destroy_trigger};
    endfunction

    task automatic push(input logic [66:0] ent, input int fall_at, input int low_len);
        exp_t e;
        e.f       = ent[57:0];
        e.fall_at = fall_at;
        e.low_len = low_len;
        exp_q.push_back(e);
    endtask

    task automatic fill_rom_end();
        for (int i = 0; i < 256; i++) rom[i] = mk(1'b1, 8'd0, 3'd0, 10'd0, 10'd0, 10'd0, 10'd0, 5'd0, 8'd0, 2'd0);
    endtask

    task automatic do_start(output int n);
        @(negedge clk_calculation);
        start = 1'b1;
        n = cyc + 1;
        @(negedge clk_calculation);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_calculation);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk_calculation);
            n++;
        end
        chk(name, done, 1);
    endtask

    // Runtime model: acks ack_delay cycles after sync falls, holds the ack
    // for ack_hold extra cycles after sync rises, or never acks.
    initial begin
        int lowcnt = 0;
        int hicnt  = 0;
        obj_bus.update_object_position = 1'b0;
        forever begin
            @(negedge clk_calculation);
            #1;
            if (obj_bus.sync_object_position === 1'b0) begin
                hicnt = 0;
                lowcnt++;
                if (!never_ack && lowcnt == ack_delay) obj_bus.update_object_position = 1'b1;
            end else begin
                lowcnt = 0;
                if (obj_bus.update_object_position) begin
                    hicnt++;
                    if (hicnt > ack_hold) obj_bus.update_object_position = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expected entry per sync fall, checks fields, issue
    // cycle, stability while low, low duration, and that ack was low first.
    initial begin
        bit   low = 0;
        bit   cur_ok = 0;
        bit   stable = 1;
        bit   ack_low_seen = 1;
        int   low_cnt = 0;
        exp_t cur;
        forever begin
            @(negedge clk_calculation);
            if (obj_bus.sync_object_position === 1'b0) begin
                if (!low) begin
                    low     = 1;
                    low_cnt = 1;
                    stable  = 1;
                    chk("ack_low_before_issue", ack_low_seen, 1);
                    if (exp_q.size() == 0) begin
                        cur_ok = 0;
                        chk("unexpected_issue_fields", bus_fields(), 0);
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_ok = 1;
                        chk("issue_fields", bus_fields(), cur.f);
                        if (cur.fall_at >= 0) chk("issue_cycle", cyc, cur.fall_at);
                    end
                end else begin
                    low_cnt++;
                    if (cur_ok && bus_fields() !== cur.f) stable = 0;
                end
            end else if (obj_bus.sync_object_position === 1'b1) begin
                if (low) begin
                    low = 0;
                    if (!abort && cur_ok) begin
                        chk("fields_stable_while_low", stable, 1);
                        if (cur.low_len >= 0) chk("sync_low_cycles", low_cnt, cur.low_len);
                    end
                    ack_low_seen = 0;
                end
                if (obj_bus.update_object_position === 1'b0) ack_low_seen = 1;
            end
        end
    end

    initial begin
        int n;
        logic [66:0] e0, e1, e2;
        reset = 1'b1;
        start = 1'b0;
        tick_centi_second = 1'b0;
        fill_rom_end();
        repeat (3) @(negedge clk_calculation);

        // Reset values
        chk("rst_sync", obj_bus.sync_object_position, 1);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dropped", dropped_count, 0);
        chk("rst_fields", bus_fields(), 0);
        reset = 1'b0;
        @(negedge clk_calculation);

        // Two issued entries, end flag at address 2
        e0 = mk(1'b0, 8'd0, 3'd1, 10'd100, 10'd200, 10'd16, 10'd16, 5'd3, 8'd40, 2'd1);
        e1 = mk(1'b0, 8'd0, 3'd6, 10'd512, 10'd7, 10'd32, 10'd64, 5'd31, 8'd255, 2'd3);
        e2 = mk(1'b1, 8'd0, 3'd2, 10'd999, 10'd888, 10'd1, 10'd2, 5'd9, 8'd77, 2'd2);
        rom[0] = e0; rom[1] = e1; rom[2] = e2;
        never_ack = 0; ack_delay = 2; ack_hold = 0;
        @(negedge clk_calculation);
        do_start(n);
        push(e0, n + 2, 2);
        push(e1, -1, 2);
        wait_cyc(n + 5);
        chk("t1_addr_after_release", rom_addr, 1);
        chk("t1_busy", busy, 1);
        wait_done("t1_done", 60);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_final_addr", rom_addr, 2);
        chk("t1_end_fields_retained", obj_bus.object_pos_x, 999);
        chk("t1_sync_at_done", obj_bus.sync_object_position, 1);
        chk("t1_dropped", dropped_count, 0);

        // Wait of 5 ticks; ticks during FETCH and LATCH are not counted
        fill_rom_end();
        e0 = mk(1'b0, 8'd5, 3'd4, 10'd300, 10'd301, 10'd20, 10'd21, 5'd7, 8'd9, 2'd0);
        rom[0] = e0;
        do_start(n);
        push(e0, n + 52, 2);
        tick_centi_second = 1'b1;
        @(negedge clk_calculation);
        tick_centi_second = 1'b1;
        @(negedge clk_calculation);
        tick_centi_second = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (9) @(negedge clk_calculation);
            tick_centi_second = 1'b1;
            @(negedge clk_calculation);
            tick_centi_second = 1'b0;
        end
        wait_done("t2_done", 40);

        // Never acked: each entry dropped after ACK_TIMEOUT cycles
        fill_rom_end();
        e0 = mk(1'b0, 8'd0, 3'd3, 10'd11, 10'd22, 10'd33, 10'd44, 5'd5, 8'd66, 2'd1);
        e1 = mk(1'b0, 8'd0, 3'd5, 10'd55, 10'd66, 10'd77, 10'd88, 5'd10, 8'd99, 2'd2);
        rom[0] = e0; rom[1] = e1;
        never_ack = 1;
        do_start(n);
        push(e0, n + 2, 8);
        push(e1, -1, 8);
        wait_cyc(n + 10);
        chk("t3_dropped_first", dropped_count, 1);
        chk("t3_sync_after_timeout", obj_bus.sync_object_position, 1);
        wait_done("t3_done", 60);
        chk("t3_dropped_final", dropped_count, 2);
        chk("t3_final_addr", rom_addr, 2);

        // Ack on the timeout cycle wins; nothing dropped
        fill_rom_end();
        rom[0] = e0;
        never_ack = 0; ack_delay = 8; ack_hold = 0;
        do_start(n);
        push(e0, n + 2, 8);
        wait_done("t3b_done", 40);
        chk("t3b_ack_wins_no_drop", dropped_count, 0);

        // Ack held 4 cycles after sync rises keeps the dispatcher in RELEASE
        fill_rom_end();
        rom[0] = e0; rom[1] = e1;
        ack_delay = 2; ack_hold = 4;
        do_start(n);
        push(e0, n + 2, 2);
        push(e1, n + 11, 2);
        wait_done("t4_done", 60);
        ack_hold = 0;
        @(negedge clk_calculation);

        // start ignored while busy; reset while in ISSUE
        fill_rom_end();
        rom[0] = e0; rom[1] = e1;
        never_ack = 1;
        do_start(n);
        push(e0, n + 2, 8);
        push(e1, n + 13, -1);
        wait_cyc(n + 4);
        start = 1'b1;
        @(negedge clk_calculation);
        start = 1'b0;
        wait_cyc(n + 11);
        chk("t5_start_ignored_addr", rom_addr, 1);
        chk("t5_start_ignored_dropped", dropped_count, 1);
        wait_cyc(n + 15);
        chk("t5_in_issue_sync", obj_bus.sync_object_position, 0);
        abort = 1;
        reset = 1'b1;
        @(negedge clk_calculation);
        chk("t5_reset_sync", obj_bus.sync_object_position, 1);
        chk("t5_reset_addr", rom_addr, 0);
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_done", done, 0);
        chk("t5_reset_dropped", dropped_count, 0);
        chk("t5_reset_fields", bus_fields(), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_calculation);
        chk("t5_stays_idle", busy, 0);
        abort = 0;

        // Full 256-entry pattern, all dropped: counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            rom[i] = mk(1'b0, 8'd0, 3'(i), 10'(i), 10'(1023 - i), 10'(i * 3), 10'(i + 7),
                        5'(i), 8'(255 - i), 2'(i));
            push(rom[i], -1, 8);
        end
        do_start(n);
        wait_done("t6_done", 3500);
        chk("t6_dropped_saturated", dropped_count, 255);
        chk("t6_last_addr", rom_addr, 255);
        chk("t6_busy", busy, 0);
        chk("t6_queue_drained", exp_q.size(), 0);
        do_start(n);
        wait_cyc(n);
        chk("t6_restart_clears_dropped", dropped_count, 0);
        chk("t6_restart_addr", rom_addr, 0);
        chk("t6_restart_busy", busy, 1);
        abort = 1;
        reset = 1'b1;
        @(negedge clk_calculation);
        reset = 1'b0;
        repeat (3) @(negedge clk_calculation);
        abort = 0;

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
